// File: rtl/mac_lane_issuer.sv
// Sequencer for one MAC lane: fetches operand words, streams them into the lane, writes results back.
// Optional stall counter output perf_stall is enabled by defining MAC_ISSUE_PERF_EN.
module mac_lane_issuer #(
    parameter int EW = 16,
    parameter int AW = 32,
    parameter int LW = 10,
    localparam int DW = 1 + AW + 2 * EW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [LW-1:0] job_len,
    input  logic [LW-1:0] job_rd_base,
    input  logic [LW-1:0] job_wr_base,
    input  logic          job_signed,
    output logic          rd_en,
    output logic [LW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          ln_in_valid,
    input  logic          ln_in_ready,
    output logic [EW-1:0] ln_a,
    output logic [EW-1:0] ln_b,
    output logic [AW-1:0] ln_c,
    output logic          ln_mask,
    output logic          ln_signed,
    input  logic          ln_out_valid,
    output logic          ln_out_ready,
    input  logic [AW-1:0] ln_y,
    output logic          wr_en,
    output logic [LW-1:0] wr_addr,
    output logic [AW-1:0] wr_data,
    output logic          busy,
    output logic          done
`ifdef MAC_ISSUE_PERF_EN
    ,
    output logic [31:0]   perf_stall
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, rd_base_q, wr_base_q;
    logic          signed_q;
    logic [LW-1:0] rd_cnt, iss_cnt, ret_cnt;
    logic          rd_pend;
    logic [DW-1:0] fifo_mem [2];
    logic          fifo_rd_ptr, fifo_wr_ptr;
    logic [1:0]    fifo_cnt;
    logic [1:0]    occ;
    logic          accept, ln_hs;
    logic [DW-1:0] head;

    assign job_ready    = (state_q == IDLE);
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign ln_out_ready = (state_q == RUN);
    assign accept       = job_valid && job_ready;

    assign head        = fifo_mem[fifo_rd_ptr];
    assign ln_a        = head[EW-1:0];
    assign ln_b        = head[2*EW-1:EW];
    assign ln_c        = head[2*EW+AW-1:2*EW];
    assign ln_mask     = head[DW-1];
    assign ln_signed   = signed_q;
    assign ln_in_valid = (fifo_cnt != 2'd0) && (iss_cnt != len_q);
    assign ln_hs       = ln_in_valid && ln_in_ready;

    // Credit counts the slot freed by a pop this cycle, otherwise back-to-back issue stalls every other cycle.
    assign occ     = fifo_cnt - {1'b0, ln_hs} + {1'b0, rd_pend};
    assign rd_en   = (state_q == RUN) && (rd_cnt < len_q) && (occ < 2'd2);
    assign rd_addr = rd_base_q + rd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (job_valid) state_d = (job_len == '0) ? DONE : RUN;
            RUN:     if (wr_en && (ret_cnt == len_q)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            signed_q  <= 1'b0;
            rd_cnt    <= '0;
            iss_cnt   <= '0;
            ret_cnt   <= '0;
            rd_pend   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            rd_pend <= rd_en;
            wr_en   <= 1'b0;
            if (accept) begin
                len_q     <= job_len;
                rd_base_q <= job_rd_base;
                wr_base_q <= job_wr_base;
                signed_q  <= job_signed;
                rd_cnt    <= '0;
                iss_cnt   <= '0;
                ret_cnt   <= '0;
            end
            if (rd_en) rd_cnt <= rd_cnt + 1'b1;
            if (ln_hs) iss_cnt <= iss_cnt + 1'b1;
            if (ln_out_valid && ln_out_ready) begin
                wr_en   <= 1'b1;
                wr_data <= ln_y;
                wr_addr <= wr_base_q + ret_cnt;
                ret_cnt <= ret_cnt + 1'b1;
            end
        end
    end

    // Two-entry operand FIFO fed by the RAM one cycle after each read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_rd_ptr <= 1'b0;
            fifo_wr_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (rd_pend) begin
                fifo_mem[fifo_wr_ptr] <= rd_data;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (ln_hs) fifo_rd_ptr <= ~fifo_rd_ptr;
            case ({rd_pend, ln_hs})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef MAC_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_stall <= '0;
        else if (accept)
            perf_stall <= '0;
        else if ((state_q == RUN) && ln_in_valid && !ln_in_ready && (perf_stall != '1))
            perf_stall <= perf_stall + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mac_lane_issuer.sv
// Testbench for mac_lane_issuer: lane and RAM models, scoreboard of expected reads and writes.
// Honours MAC_ISSUE_PERF_EN to also check perf_stall.
module tb_mac_lane_issuer;
    localparam int EW = 16;
    localparam int AW = 32;
    localparam int LW = 10;
    localparam int DW = 1 + AW + 2 * EW;

    logic          clk;
    logic          rst_n;
    logic          job_valid, job_ready, job_signed;
    logic [LW-1:0] job_len, job_rd_base, job_wr_base;
    logic          rd_en;
    logic [LW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          ln_in_valid, ln_in_ready;
    logic [EW-1:0] ln_a, ln_b;
    logic [AW-1:0] ln_c;
    logic          ln_mask, ln_signed;
    logic          ln_out_valid, ln_out_ready;
    logic [AW-1:0] ln_y;
    logic          wr_en;
    logic [LW-1:0] wr_addr;
    logic [AW-1:0] wr_data;
    logic          busy, done;
`ifdef MAC_ISSUE_PERF_EN
    logic [31:0]   perf_stall;
`endif

    mac_lane_issuer #(.EW(EW), .AW(AW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
        .job_rd_base(job_rd_base), .job_wr_base(job_wr_base), .job_signed(job_signed),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .ln_in_valid(ln_in_valid), .ln_in_ready(ln_in_ready),
        .ln_a(ln_a), .ln_b(ln_b), .ln_c(ln_c), .ln_mask(ln_mask), .ln_signed(ln_signed),
        .ln_out_valid(ln_out_valid), .ln_out_ready(ln_out_ready), .ln_y(ln_y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
`ifdef MAC_ISSUE_PERF_EN
        , .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cur_cyc = 0;
    int t0 = 0;
    int ready_mode = 0;
    int done_cyc = -1;
    bit done_seen = 0;
    bit prev_done = 0;
    int wr_seen = 0;
    int stall_cnt = 0;
    logic [AW-1:0] last_wr_data;
    logic [LW-1:0] last_wr_addr;
    logic [DW-1:0] ram [1024];
    logic [LW-1:0] exp_rd_q [$];
    logic [LW-1:0] exp_wa_q [$];
    logic [AW-1:0] exp_wd_q [$];
    int rd_log [$];
    int hs_log [$];
    int wr_log [$];

    always @(posedge clk) cur_cyc <= cur_cyc + 1;

    // Behavioural lane result: plain integer multiply-add, or pass c through when masked.
    function automatic logic [AW-1:0] refModel(logic [DW-1:0] w, bit sg);
        longint a, b, c;
        logic [63:0] y;
        a = sg ? longint'($signed(w[15:0]))  : longint'(w[15:0]);
        b = sg ? longint'($signed(w[31:16])) : longint'(w[31:16]);
        c = longint'(w[63:32]);
        y = 64'(c + a * b);
        return w[DW-1] ? w[63:32] : y[31:0];
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    // Two-cycle in-order lane model sharing rst_n.
    logic          s1_v, s2_v;
    logic [AW-1:0] s1_y, s2_y;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 0; s2_v <= 0; s1_y <= '0; s2_y <= '0;
        end else begin
            s1_v <= ln_in_valid && ln_in_ready;
            s1_y <= refModel({ln_mask, ln_c, ln_b, ln_a}, ln_signed);
            s2_v <= s1_v;
            s2_y <= s1_y;
        end
    end
    assign ln_out_valid = s2_v;
    assign ln_y         = s2_y;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       ln_in_ready = 1'b1;
            1:       ln_in_ready = !ln_in_ready;
            default: ln_in_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops the scoreboard on every read strobe and write, and logs event cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) checkOutput("job_ready_after_done", job_ready, 1);
            prev_done = done;
            if (rd_en) begin
                rd_log.push_back(cur_cyc - t0);
                if (exp_rd_q.size() == 0) checkOutput("rd_en_unexpected", rd_en, 0);
                else checkOutput("rd_addr", rd_addr, exp_rd_q.pop_front());
            end
            if (ln_in_valid && ln_in_ready) hs_log.push_back(cur_cyc - t0);
            if (busy && ln_in_valid && !ln_in_ready) stall_cnt++;
            if (wr_en) begin
                wr_log.push_back(cur_cyc - t0);
                wr_seen++;
                last_wr_data = wr_data;
                last_wr_addr = wr_addr;
                if (exp_wa_q.size() == 0) checkOutput("wr_en_unexpected", wr_en, 0);
                else begin
                    checkOutput("wr_addr", wr_addr, exp_wa_q.pop_front());
                    checkOutput("wr_data", wr_data, exp_wd_q.pop_front());
                end
            end
            if (done) begin
                done_seen = 1;
                done_cyc  = cur_cyc - t0;
                checkOutput("busy_in_done", busy, 0);
            end
        end else begin
            prev_done = 0;
        end
    end

    task automatic applyStimulus(int len, int rb, int wb, bit sg);
        @(negedge clk);
        checkOutput("job_ready_idle", job_ready, 1);
        for (int i = 0; i < len; i++) begin
            exp_rd_q.push_back(LW'(rb + i));
            exp_wa_q.push_back(LW'(wb + i));
            exp_wd_q.push_back(refModel(ram[LW'(rb + i)], sg));
        end
        rd_log.delete(); hs_log.delete(); wr_log.delete();
        done_seen = 0; done_cyc = -1; wr_seen = 0; stall_cnt = 0;
        job_len = LW'(len); job_rd_base = LW'(rb); job_wr_base = LW'(wb); job_signed = sg;
        job_valid = 1'b1;
        t0 = cur_cyc;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic waitDone(int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_seen) checkOutput("done_timeout", done_seen, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rd_queue_drained", exp_rd_q.size(), 0);
        checkOutput("wr_queue_drained", exp_wa_q.size(), 0);
    endtask

    task automatic checkResetOutputs(string tag);
        checkOutput({tag, "_job_ready"}, job_ready, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_rd_en"}, rd_en, 0);
        checkOutput({tag, "_rd_addr"}, rd_addr, 0);
        checkOutput({tag, "_ln_in_valid"}, ln_in_valid, 0);
        checkOutput({tag, "_ln_a"}, ln_a, 0);
        checkOutput({tag, "_ln_b"}, ln_b, 0);
        checkOutput({tag, "_ln_c"}, ln_c, 0);
        checkOutput({tag, "_ln_mask"}, ln_mask, 0);
        checkOutput({tag, "_ln_signed"}, ln_signed, 0);
        checkOutput({tag, "_ln_out_ready"}, ln_out_ready, 0);
        checkOutput({tag, "_wr_en"}, wr_en, 0);
        checkOutput({tag, "_wr_addr"}, wr_addr, 0);
        checkOutput({tag, "_wr_data"}, wr_data, 0);
`ifdef MAC_ISSUE_PERF_EN
        checkOutput({tag, "_perf_stall"}, perf_stall, 0);
`endif
    endtask

    task automatic clearScoreboard();
        exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    endtask

    initial begin
        int n;
        int exp_hs [4] = '{3, 4, 5, 6};
        int exp_wr [4] = '{6, 7, 8, 9};
        rst_n = 1'b0; job_valid = 1'b0; job_len = '0; job_rd_base = '0;
        job_wr_base = '0; job_signed = 1'b0; ln_in_ready = 1'b1;
        for (int i = 0; i < 1024; i++)
            ram[i] = {1'($urandom_range(0, 3) == 0), 32'($urandom), 16'($urandom), 16'($urandom)};
        ram[5] = {1'b0, 32'd100, 16'd3, 16'd4};
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single element job");
        ready_mode = 0;
        applyStimulus(1, 5, 9, 1);
        waitDone(60);
        checkOutput("t1_first_rd_cycle", rd_log.size() > 0 ? rd_log[0] : -1, 1);
        checkOutput("t1_wr_cycle", wr_log.size() > 0 ? wr_log[0] : -1, 6);
        checkOutput("t1_wr_addr", last_wr_addr, 9);
        checkOutput("t1_wr_data", last_wr_data, 112);
        checkOutput("t1_done_cycle", done_cyc, 7);

        $display("[TB] four element back-to-back job");
        applyStimulus(4, 20, 40, 0);
        waitDone(60);
        checkOutput("t2_hs_count", hs_log.size(), 4);
        checkOutput("t2_wr_count", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2_hs_cycle%0d", i), hs_log.size() > i ? hs_log[i] : -1, exp_hs[i]);
            checkOutput($sformatf("t2_wr_cycle%0d", i), wr_log.size() > i ? wr_log[i] : -1, exp_wr[i]);
        end
        checkOutput("t2_done_cycle", done_cyc, 10);

        $display("[TB] eight element job with toggling lane ready");
        ready_mode = 1;
        applyStimulus(8, 100, 200, 1);
        waitDone(100);
        checkOutput("t3_wr_count", wr_seen, 8);
`ifdef MAC_ISSUE_PERF_EN
        checkOutput("t3_perf_stall", perf_stall, stall_cnt);
`endif

        $display("[TB] address wrap");
        ready_mode = 0;
        applyStimulus(4, 1022, 1021, 0);
        waitDone(60);
        checkOutput("t4_rd_count", rd_log.size(), 4);

        $display("[TB] zero length job");
        applyStimulus(0, 50, 60, 0);
        waitDone(20);
        checkOutput("t5_done_cycle", done_cyc, 1);
        checkOutput("t5_rd_count", rd_log.size(), 0);
        checkOutput("t5_wr_count", wr_seen, 0);

        $display("[TB] reset in the middle of a job");
        applyStimulus(6, 300, 400, 0);
        n = 0;
        while (wr_seen < 2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_two_writes_seen", wr_seen >= 2, 1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        clearScoreboard();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2, 500, 600, 1);
        waitDone(60);
        checkOutput("t6_after_reset_writes", wr_seen, 2);

        $display("[TB] randomized jobs");
        ready_mode = 2;
        for (int j = 0; j < 6; j++) begin
            int len = $urandom_range(1, 24);
            applyStimulus(len, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
            waitDone(400);
            checkOutput($sformatf("rand%0d_wr_count", j), wr_seen, len);
`ifdef MAC_ISSUE_PERF_EN
            checkOutput($sformatf("rand%0d_perf_stall", j), perf_stall, stall_cnt);
`endif
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mac_lane_issuer.md
# mac_lane_issuer

Initiator-side sequencer for one MAC lane in the vector MAC datapath.
- Accepts a job (element count, operand base, result base, signedness) and fetches packed operand words from a 1-cycle-latency operand RAM.
- Streams the fetched operands into the lane over its valid/ready input handshake.
- Collects the lane's results and writes them to the result RAM.
- Pulses `done` once the final result has been written.
- Sits between the vector controller and each `mac_lane` instance.

## Interface
- `EW`, 16, element width of `a`/`b`
- `AW`, 32, accumulator/result width
- `LW`, 10, job length and address width; max job length is 2^LW-1
- `DW`, derived as 1+AW+2*EW; operand word layout is {mask, c, b, a}, with `a` in the LSBs
- `clk`  in  1  clock; all logic on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `job_valid`  in  1  job request
- `job_ready`  out  1  high only in IDLE
- `job_len`  in  LW  number of elements
- `job_rd_base`  in  LW  first operand address
- `job_wr_base`  in  LW  first result address
- `job_signed`  in  1  drives `ln_signed` for the whole job
- `rd_en`  out  1  operand RAM read strobe
- `rd_addr`  out  LW  operand RAM address
- `rd_data`  in  DW  valid exactly one cycle after `rd_en`
- `ln_in_valid`  out  1  lane input valid
- `ln_in_ready`  in  1  lane input ready
- `ln_a`, `ln_b`  out  EW  operands
- `ln_c`  out  AW  addend
- `ln_mask`  out  1  lane bypass
- `ln_signed`  out  1  signedness
- `ln_out_valid`  in  1  lane result valid
- `ln_out_ready`  out  1  lane result ready
- `ln_y`  in  AW  lane result
- `wr_en`  out  1  result RAM write strobe
- `wr_addr`  out  LW  result RAM address
- `wr_data`  out  AW  result RAM data
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse at job end

## Operation
- States:
  - IDLE: on `job_valid && job_ready`, latch the job and go to RUN. If `job_len==0`, go to DONE instead; no read or write is issued.
  - RUN: three counters run concurrently:
    - `rd_cnt` counts reads issued.
    - `iss_cnt` counts lane handshakes.
    - `ret_cnt` counts results written.
    - When `ret_cnt` reaches `job_len` on a write, go to DONE.
  - DONE: assert `done` for one cycle, then return to IDLE.
- Reads:
  - `rd_en` is asserted when `rd_cnt < job_len` and (reads in flight + FIFO occupancy) < 2.
  - `rd_addr = job_rd_base + rd_cnt`, wrapping modulo 2^LW.
- Operand FIFO:
  - 2 entries; captures `rd_data` in the cycle after `rd_en`.
  - The head drives `ln_a`/`ln_b`/`ln_c`/`ln_mask`; `ln_in_valid` = FIFO not empty.
  - Pop on `ln_in_valid && ln_in_ready`.
  - A simultaneous push and pop with one entry keeps occupancy at 1.
  - It never overflows, because the credit check covers reads in flight.
- Results:
  - `ln_out_ready` = 1 in RUN and 0 otherwise.
  - Each `ln_out_valid` in RUN registers `wr_en=1`, `wr_data=ln_y`, `wr_addr=job_wr_base+ret_cnt` (wrapping) for the next cycle.
- Operand order, issue order and write order are identical. The lane is in-order, so results are written back in element order.

## Timing
- Reset values of every output: `job_ready=1`; `busy=0`; `done=0`; `rd_en=0`; `rd_addr=0`; `ln_in_valid=0`; `ln_a`/`ln_b`/`ln_c`/`ln_mask`/`ln_signed=0`; `ln_out_ready=0`; `wr_en=0`; `wr_addr=0`; `wr_data=0`.
- Cycle timeline, with job accepted at cycle 0:
  - cycle 1: first `rd_en`
  - cycle 2: `rd_data` valid, pushed into the FIFO
  - cycle 3: first `ln_in_valid`
- With the lane never stalling, `wr_en` occurs exactly 3 cycles after each input handshake (2-cycle lane plus 1 register).
- `done` is high the cycle after the last `wr_en`, with `busy=0` in that cycle. `job_ready` returns the following cycle.
- Sustained throughput is 1 element per cycle when `ln_in_ready` is held high.
- `ln_in_valid` and the operand fields are held stable until the handshake completes.
- Reset mid-job: all state clears immediately and any partial results are abandoned. The lane must share `rst_n` so no stale result returns.

## Configuration
- `MAC_ISSUE_PERF_EN`:
  - Defined: adds output `perf_stall` (32 bits). It is cleared on job accept and counts RUN cycles with `ln_in_valid && !ln_in_ready`. It saturates at all-ones, holds its value after `done`, and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- `job_len=1`, rd_base=5, wr_base=9, RAM[5]={0, c=100, b=3, a=4}, signed:
  - `rd_en` with `rd_addr=5` at cycle 1.
  - `wr_en` with `wr_addr=9`, `wr_data=112`.
  - `done` one cycle later.
- `job_len=4`, `ln_in_ready` held 1: four consecutive `ln_in_valid` handshakes at cycles 3–6, `wr_en` at cycles 6–9, `done` at cycle 10.
- `job_len=8` with `ln_in_ready` toggled 1/0 every cycle:
  - FIFO never exceeds 2 entries.
  - Results are written to wr_base..wr_base+7 in order.
  - With the macro defined, `perf_stall` = number of stalled cycles.
- Address wrap, `LW=10`, rd_base=1022, `job_len=4`: `rd_addr` sequence 1022, 1023, 0, 1.
- `job_len=0`: no `rd_en`, no `wr_en`, `done` at cycle 1, `job_ready` high again at cycle 2.
- `rst_n` low mid-job (after 2 of 6 writes): all outputs at reset values immediately. A new job of length 2 then completes correctly.
